// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 8-point FFT output path.
package fft_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned NPT   = 8;
  localparam int unsigned LOG2N = 3;

  localparam logic BANK_EMPTY = 1'b0;
  localparam logic BANK_FULL  = 1'b1;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft8_out_reorder_if.sv
// Frame-in / word-out handshake bundle for the FFT output reorder block.
interface fft8_out_reorder_if;
  import fft_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [NPT*DW-1:0]     in_re;
  logic [NPT*DW-1:0]     in_im;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_re;
  logic [DW-1:0]         out_im;
  logic [LOG2N-1:0]      out_idx;
  logic                  out_last;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last
  );

endinterface

// File: rtl/fft8_frame_bank.sv
// One frame buffer: parallel bit-reverse scatter load, indexed read, full flag.
module fft8_frame_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [NPT*DW-1:0] in_re_i,
  input  logic [NPT*DW-1:0] in_im_i,
  input  logic [LOG2N-1:0]  rd_idx_i,
  output logic              full_o,
  output logic [DW-1:0]     rd_re_o,
  output logic [DW-1:0]     rd_im_o
);

  logic [DW-1:0] re_q [NPT];
  logic [DW-1:0] re_d [NPT];
  logic [DW-1:0] im_q [NPT];
  logic [DW-1:0] im_d [NPT];
  logic          full_q, full_d;

  always_comb begin
    re_d   = re_q;
    im_d   = im_q;
    full_d = full_q;
    if (load_i) begin
      // Lane k carries X[bitrev(k)]; store it at its natural-order slot.
      for (int k = 0; k < NPT; k++) begin
        re_d[bitrev3(LOG2N'(k))] = in_re_i[DW*k +: DW];
        im_d[bitrev3(LOG2N'(k))] = in_im_i[DW*k +: DW];
      end
      full_d = BANK_FULL;
    end else if (clr_i) begin
      full_d = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NPT; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
      full_q <= BANK_EMPTY;
    end else begin
      re_q   <= re_d;
      im_q   <= im_d;
      full_q <= full_d;
    end
  end

  always_comb begin
    full_o  = full_q;
    rd_re_o = re_q[rd_idx_i];
    rd_im_o = im_q[rd_idx_i];
  end

endmodule

// File: rtl/fft8_out_reorder.sv
// Ping-pong reorder buffer: accepts bit-reversed parallel frames, streams natural order.
module fft8_out_reorder
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fft8_out_reorder_if.slave   bus
);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;

  logic [1:0]       full;
  logic [1:0]       load;
  logic [1:0]       clr;
  logic [DW-1:0]    rd_re [2];
  logic [DW-1:0]    rd_im [2];

  logic in_ready, out_valid, accept, pop, last_beat;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft8_frame_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load[b]),
      .clr_i    (clr[b]),
      .in_re_i  (bus.in_re),
      .in_im_i  (bus.in_im),
      .rd_idx_i (rd_idx_q),
      .full_o   (full[b]),
      .rd_re_o  (rd_re[b]),
      .rd_im_o  (rd_im[b])
    );
  end

  // Handshake decode: in_ready depends on registered state only.
  always_comb begin
    in_ready  = (full[wr_bank_q] == BANK_EMPTY);
    out_valid = (full[rd_bank_q] == BANK_FULL);
    accept    = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready;
    last_beat = (rd_idx_q == LOG2N'(NPT - 1));

    load            = '0;
    clr             = '0;
    load[wr_bank_q] = accept;
    clr[rd_bank_q]  = pop & last_beat;

    wr_bank_d = wr_bank_q ^ accept;
    rd_bank_d = rd_bank_q ^ (pop & last_beat);
    rd_idx_d  = pop ? rd_idx_q + LOG2N'(1) : rd_idx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid;
    bus.out_idx   = rd_idx_q;
    bus.out_last  = out_valid & last_beat;
    bus.out_re    = out_valid ? rd_re[rd_bank_q] : '0;
    bus.out_im    = out_valid ? rd_im[rd_bank_q] : '0;
  end

endmodule

// File: tb/tb_fft8_out_reorder.sv
// Bench for fft8_out_reorder: frame-queue model checked every cycle plus directed literals.
module tb_fft8_out_reorder;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft8_out_reorder_if bus ();

  fft8_out_reorder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [2:0]    idx;
  } word_t;

  word_t mq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    model_ok = 1'b0;
  int    cyc = 0;
  bit    exp_rdy, exp_vld;

  int got_re[$];
  int got_idx[$];
  int got_last[$];
  int got_cyc[$];
  int acc_cyc[$];

  function automatic int rev3(int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of natural-order words; a frame is buffered while any of its words remain.
  always @(negedge clk) begin
    cyc++;
    exp_rdy = ((mq.size() + 7) / 8) < 2;
    exp_vld = mq.size() > 0;
    if (model_ok) begin
      check("in_ready", int'(bus.in_ready), int'(exp_rdy));
      check("out_valid", int'(bus.out_valid), int'(exp_vld));
      if (exp_vld) begin
        check("out_re", int'($signed(bus.out_re)), int'($signed(mq[0].re)));
        check("out_im", int'($signed(bus.out_im)), int'($signed(mq[0].im)));
        check("out_idx", int'(bus.out_idx), int'(mq[0].idx));
        check("out_last", int'(bus.out_last), int'(mq[0].idx == 3'd7));
      end else begin
        check("idle_re", int'(bus.out_re), 0);
        check("idle_im", int'(bus.out_im), 0);
        check("idle_idx", int'(bus.out_idx), 0);
        check("idle_last", int'(bus.out_last), 0);
      end
    end
    if (rst) begin
      mq.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (exp_vld && bus.out_ready) begin
        got_re.push_back(int'($signed(bus.out_re)));
        got_idx.push_back(int'(bus.out_idx));
        got_last.push_back(int'(bus.out_last));
        got_cyc.push_back(cyc);
        void'(mq.pop_front());
      end
      if (exp_rdy && bus.in_valid) begin
        acc_cyc.push_back(cyc);
        for (int n = 0; n < 8; n++) begin
          word_t w;
          w.re  = bus.in_re[DW*rev3(n) +: DW];
          w.im  = bus.in_im[DW*rev3(n) +: DW];
          w.idx = 3'(n);
          mq.push_back(w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_re.delete();
    got_idx.delete();
    got_last.delete();
    got_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic set_frame(int base);
    for (int k = 0; k < 8; k++) begin
      bus.in_re[DW*k +: DW] = DW'(base + k);
      bus.in_im[DW*k +: DW] = DW'(-(base + k));
    end
  endtask

  task automatic wait_beats(int n, int budget);
    int t = 0;
    while (got_re.size() < n && t < budget) begin
      step();
      t++;
    end
    check("drain_timeout", int'(got_re.size() >= n), 1);
  endtask

  task automatic wait_idx(int idx, int budget);
    int t = 0;
    while (!(bus.out_valid && int'(bus.out_idx) == idx) && t < budget) begin
      step();
      t++;
    end
    check("idx_timeout", int'(bus.out_valid && int'(bus.out_idx) == idx), 1);
  endtask

  task automatic check_frame(string name, int off, int base);
    for (int n = 0; n < 8; n++) begin
      if (off + n < got_re.size()) begin
        check(name, got_re[off+n], base + rev3(n));
        check({name, "_idx"}, got_idx[off+n], n);
      end else begin
        check({name, "_missing"}, got_re.size(), off + 8);
      end
    end
  endtask

  initial begin
    int exp2[8];
    bit done;
    bit rdy;
    exp2 = '{100, 104, 102, 106, 101, 105, 103, 107};
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;

    // 1: reset held two cycles
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t1_in_ready", int'(bus.in_ready), 1);
    check("t1_out_valid", int'(bus.out_valid), 0);
    check("t1_out_re", int'(bus.out_re), 0);
    check("t1_out_im", int'(bus.out_im), 0);
    check("t1_out_idx", int'(bus.out_idx), 0);

    // 2: single frame reorder
    step();
    clear_logs();
    bus.out_ready = 1'b1;
    set_frame(100);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_beats(8, 20);
    for (int n = 0; n < 8; n++) begin
      if (n < got_re.size()) begin
        check("t2_re", got_re[n], exp2[n]);
        check("t2_idx", got_idx[n], n);
        check("t2_last", got_last[n], int'(n == 7));
      end
    end
    @(negedge clk);
    check("t2_valid_drop", int'(bus.out_valid), 0);

    // 3: back-to-back frames
    step();
    clear_logs();
    set_frame(0);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("t3_rdy_a", int'(bus.in_ready), 1);
    step();
    set_frame(16);
    @(negedge clk);
    check("t3_rdy_b", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    wait_beats(16, 40);
    check_frame("t3_a", 0, 0);
    check_frame("t3_b", 8, 16);
    if (got_cyc.size() >= 16 && acc_cyc.size() >= 1) begin
      check("t3_contig", got_cyc[15] - got_cyc[0], 15);
      check("t3_latency", got_cyc[0] - acc_cyc[0], 1);
    end

    // 4: both banks full under backpressure
    step();
    clear_logs();
    bus.out_ready = 1'b0;
    set_frame(32);
    bus.in_valid = 1'b1;
    step();
    set_frame(48);
    step();
    set_frame(64);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_rdy_full", int'(bus.in_ready), 0);
      step();
    end
    bus.out_ready = 1'b1;
    done = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      step();
      if (rdy) begin
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
    end
    check("t4_accept3", int'(done), 1);
    bus.in_valid = 1'b0;
    wait_beats(24, 60);
    check("t4_n_accepted", acc_cyc.size(), 3);
    if (acc_cyc.size() >= 3 && got_cyc.size() >= 8)
      check("t4_accept_timing", acc_cyc[2], got_cyc[7] + 1);
    check_frame("t4_f1", 0, 32);
    check_frame("t4_f2", 8, 48);
    check_frame("t4_f3", 16, 64);

    // 5: stall at index 3
    step();
    clear_logs();
    set_frame(200);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_idx(3, 20);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_idx", int'(bus.out_idx), 3);
      check("t5_hold_re", int'($signed(bus.out_re)), 206);
      check("t5_hold_im", int'($signed(bus.out_im)), -206);
      step();
    end
    bus.out_ready = 1'b1;
    wait_beats(8, 20);
    repeat (3) step();
    check("t5_count", got_re.size(), 8);
    check_frame("t5", 0, 200);

    // 6: reset mid-drain with second bank full
    clear_logs();
    bus.out_ready = 1'b0;
    set_frame(300);
    bus.in_valid = 1'b1;
    step();
    set_frame(400);
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_idx(5, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid", int'(bus.out_valid), 0);
    check("t6_ready", int'(bus.in_ready), 1);
    step();
    clear_logs();
    set_frame(500);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_beats(8, 20);
    repeat (4) step();
    check("t6_count", got_re.size(), 8);
    check_frame("t6", 0, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
